// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline: datapath widths, ALU and
// operand-select encodings, and the ID/EX pipeline record.
package core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  // ALU operation encodings. ALU_ADD is all-zero so a cleared register reads as ADD.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // ALU B-operand select encodings.
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // Everything the execute stage needs, held in one record.
  typedef struct packed {
    logic [3:0]      alu_code;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rd_addr;
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic            mem_to_reg;
    logic            valid;
  } id_ex_t;

  // A bubble is the all-zero record: ADD, no writes, no memory access, invalid.
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus for the ID/EX pipeline register.
// master: the decode side (drives *_id and the flush), slave: the stage itself.
// Optional counters present when ID_EX_PERF_CNT_EN is defined.
interface id_ex_stage_if
  import core_pkg::*;
  ();

  logic [3:0]      ALUCode_id;
  logic            ALUSrcA_id;
  logic [1:0]      ALUSrcB_id;
  logic [XLEN-1:0] Imm_id;
  logic [RA_W-1:0] rs1Addr_id;
  logic [RA_W-1:0] rs2Addr_id;
  logic            rs1Used_id;
  logic            rs2Used_id;
  logic [XLEN-1:0] rs1Data_id;
  logic [XLEN-1:0] rs2Data_id;
  logic [XLEN-1:0] PC_id;
  logic [RA_W-1:0] rdAddr_id;
  logic            RegWrite_id;
  logic            MemWrite_id;
  logic            MemRead_id;
  logic            MemtoReg_id;
  logic            BranchTaken_ex;

  logic [3:0]      ALUCode_ex;
  logic            ALUSrcA_ex;
  logic [1:0]      ALUSrcB_ex;
  logic [XLEN-1:0] Imm_ex;
  logic [RA_W-1:0] rs1Addr_ex;
  logic [RA_W-1:0] rs2Addr_ex;
  logic [XLEN-1:0] rs1Data_ex;
  logic [XLEN-1:0] rs2Data_ex;
  logic [XLEN-1:0] PC_ex;
  logic [RA_W-1:0] rdAddr_ex;
  logic            RegWrite_ex;
  logic            MemWrite_ex;
  logic            MemRead_ex;
  logic            MemtoReg_ex;
  logic            Valid_ex;
  logic            Stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]     StallCnt;
  logic [31:0]     FlushCnt;
`endif

  modport master (
    output ALUCode_id, ALUSrcA_id, ALUSrcB_id, Imm_id,
           rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           rs1Data_id, rs2Data_id, PC_id, rdAddr_id,
           RegWrite_id, MemWrite_id, MemRead_id, MemtoReg_id,
           BranchTaken_ex,
    input  ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, Imm_ex,
           rs1Addr_ex, rs2Addr_ex, rs1Data_ex, rs2Data_ex, PC_ex, rdAddr_ex,
           RegWrite_ex, MemWrite_ex, MemRead_ex, MemtoReg_ex,
           Valid_ex, Stall
`ifdef ID_EX_PERF_CNT_EN
           , StallCnt, FlushCnt
`endif
  );

  modport slave (
    input  ALUCode_id, ALUSrcA_id, ALUSrcB_id, Imm_id,
           rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           rs1Data_id, rs2Data_id, PC_id, rdAddr_id,
           RegWrite_id, MemWrite_id, MemRead_id, MemtoReg_id,
           BranchTaken_ex,
    output ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, Imm_ex,
           rs1Addr_ex, rs2Addr_ex, rs1Data_ex, rs2Data_ex, PC_ex, rdAddr_ex,
           RegWrite_ex, MemWrite_ex, MemRead_ex, MemtoReg_ex,
           Valid_ex, Stall
`ifdef ID_EX_PERF_CNT_EN
           , StallCnt, FlushCnt
`endif
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads the
// register a load currently in EX is about to write. x0 never conflicts.
module hazard_detect
  import core_pkg::*;
(
  input  logic [RA_W-1:0] rs1_addr_i,
  input  logic [RA_W-1:0] rs2_addr_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  input  logic [RA_W-1:0] rd_addr_ex_i,
  input  logic            mem_read_ex_i,
  input  logic            valid_ex_i,
  output logic            hazard_o
);

  logic load_in_ex;
  logic rs1_match;
  logic rs2_match;

  assign load_in_ex = mem_read_ex_i & valid_ex_i & (rd_addr_ex_i != '0);
  assign rs1_match  = rs1_used_i & (rs1_addr_i == rd_addr_ex_i);
  assign rs2_match  = rs2_used_i & (rs2_addr_i == rd_addr_ex_i);
  // A double match is still one hazard, hence a single stall cycle.
  assign hazard_o   = load_in_ex & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core. Captures decode
// controls/operands, inserts bubbles on load-use hazards and on taken
// control transfers, and raises Stall to hold PC and IF/ID.
// Optional stall/flush counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  logic   hazard;
  id_ex_t ex_d;
  id_ex_t ex_q;
  id_ex_t id_rec;

  hazard_detect u_hazard_detect (
    .rs1_addr_i    (bus.rs1Addr_id),
    .rs2_addr_i    (bus.rs2Addr_id),
    .rs1_used_i    (bus.rs1Used_id),
    .rs2_used_i    (bus.rs2Used_id),
    .rd_addr_ex_i  (ex_q.rd_addr),
    .mem_read_ex_i (ex_q.mem_read),
    .valid_ex_i    (ex_q.valid),
    .hazard_o      (hazard)
  );

  // A taken branch kills the ID instruction, so holding it would be pointless.
  assign bus.Stall = hazard & ~bus.BranchTaken_ex;

  // Select next EX contents: flush and hazard both load a bubble, else capture ID.
  always_comb begin
    id_rec            = ID_EX_BUBBLE;
    id_rec.alu_code   = bus.ALUCode_id;
    id_rec.alu_src_a  = bus.ALUSrcA_id;
    id_rec.alu_src_b  = bus.ALUSrcB_id;
    id_rec.imm        = bus.Imm_id;
    id_rec.rs1_addr   = bus.rs1Addr_id;
    id_rec.rs2_addr   = bus.rs2Addr_id;
    id_rec.rs1_data   = bus.rs1Data_id;
    id_rec.rs2_data   = bus.rs2Data_id;
    id_rec.pc         = bus.PC_id;
    id_rec.rd_addr    = bus.rdAddr_id;
    id_rec.reg_write  = bus.RegWrite_id;
    id_rec.mem_write  = bus.MemWrite_id;
    id_rec.mem_read   = bus.MemRead_id;
    id_rec.mem_to_reg = bus.MemtoReg_id;
    id_rec.valid      = 1'b1;

    ex_d = id_rec;
    if (bus.BranchTaken_ex || hazard) begin
      ex_d = ID_EX_BUBBLE;
    end
  end

  // Pipeline register; reset forces a bubble immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= ID_EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ALUCode_ex  = ex_q.alu_code;
  assign bus.ALUSrcA_ex  = ex_q.alu_src_a;
  assign bus.ALUSrcB_ex  = ex_q.alu_src_b;
  assign bus.Imm_ex      = ex_q.imm;
  assign bus.rs1Addr_ex  = ex_q.rs1_addr;
  assign bus.rs2Addr_ex  = ex_q.rs2_addr;
  assign bus.rs1Data_ex  = ex_q.rs1_data;
  assign bus.rs2Data_ex  = ex_q.rs2_data;
  assign bus.PC_ex       = ex_q.pc;
  assign bus.rdAddr_ex   = ex_q.rd_addr;
  assign bus.RegWrite_ex = ex_q.reg_write;
  assign bus.MemWrite_ex = ex_q.mem_write;
  assign bus.MemRead_ex  = ex_q.mem_read;
  assign bus.MemtoReg_ex = ex_q.mem_to_reg;
  assign bus.Valid_ex    = ex_q.valid;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  // Event counters; plain unsigned addition wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.Stall)          stall_cnt_d = stall_cnt_q + 32'd1;
    if (bus.BranchTaken_ex) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallCnt = stall_cnt_q;
  assign bus.FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use stall,
// false-hazard filters, flush priority, back-to-back flush, mid-stall reset.
module tb_id_ex_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  id_ex_stage_if bus_if ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one decode-stage instruction; unlisted fields get fixed nonzero values.
  task automatic drive(input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic rs1u,
                       input logic [4:0] rs2, input logic rs2u,
                       input logic [4:0] rd, input logic regw,
                       input logic memr, input logic memw);
    bus_if.ALUCode_id  = 4'd3;
    bus_if.ALUSrcA_id  = 1'b1;
    bus_if.ALUSrcB_id  = 2'd1;
    bus_if.Imm_id      = imm;
    bus_if.rs1Addr_id  = rs1;
    bus_if.rs1Used_id  = rs1u;
    bus_if.rs2Addr_id  = rs2;
    bus_if.rs2Used_id  = rs2u;
    bus_if.rs1Data_id  = 32'hAAAA_0001;
    bus_if.rs2Data_id  = 32'hBBBB_0002;
    bus_if.PC_id       = pc;
    bus_if.rdAddr_id   = rd;
    bus_if.RegWrite_id = regw;
    bus_if.MemRead_id  = memr;
    bus_if.MemWrite_id = memw;
    bus_if.MemtoReg_id = memr;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus_if.BranchTaken_ex = 1'b0;
    drive(32'h100, 32'h1234, 5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("reset_pc",     bus_if.PC_ex, 32'h0);
    chk("reset_valid",  bus_if.Valid_ex, 32'h0);
    chk("reset_regw",   bus_if.RegWrite_ex, 32'h0);
    chk("reset_memr",   bus_if.MemRead_ex, 32'h0);
    chk("reset_alu",    bus_if.ALUCode_ex, 32'h0);
    chk("reset_imm",    bus_if.Imm_ex, 32'h0);
    chk("reset_stall",  bus_if.Stall, 32'h0);
    reset = 1'b0;

    // Plain pass-through
    drive(32'h40, 32'hFFFF_FFF0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pass_pc",    bus_if.PC_ex, 32'h40);
    chk("pass_imm",   bus_if.Imm_ex, 32'hFFFF_FFF0);
    chk("pass_rd",    bus_if.rdAddr_ex, 32'd5);
    chk("pass_valid", bus_if.Valid_ex, 32'h1);
    chk("pass_regw",  bus_if.RegWrite_ex, 32'h1);
    chk("pass_alu",   bus_if.ALUCode_ex, 32'd3);
    chk("pass_rs1d",  bus_if.rs1Data_ex, 32'hAAAA_0001);
    chk("pass_srcb",  bus_if.ALUSrcB_ex, 32'd1);

    // Load-use on rs2: lw x5 then a consumer of x5
    drive(32'h44, 32'h8, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    chk("lu_memr_ex", bus_if.MemRead_ex, 32'h1);
    drive(32'h48, 32'h0, 5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall", bus_if.Stall, 32'h1);
    tick();
    chk("lu_bub_valid", bus_if.Valid_ex, 32'h0);
    chk("lu_bub_regw",  bus_if.RegWrite_ex, 32'h0);
    chk("lu_bub_pc",    bus_if.PC_ex, 32'h0);
    chk("lu_stall_drop", bus_if.Stall, 32'h0);
    tick();
    chk("lu_held_pc",    bus_if.PC_ex, 32'h48);
    chk("lu_held_valid", bus_if.Valid_ex, 32'h1);
    chk("lu_held_rs2",   bus_if.rs2Addr_ex, 32'd5);
    chk("lu_held_rd",    bus_if.rdAddr_ex, 32'd6);

    // Load to x0 must not stall
    drive(32'h50, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("x0_memr_ex", bus_if.MemRead_ex, 32'h1);
    drive(32'h54, 32'h0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    chk("x0_stall", bus_if.Stall, 32'h0);
    tick();
    chk("x0_pc",    bus_if.PC_ex, 32'h54);
    chk("x0_valid", bus_if.Valid_ex, 32'h1);

    // Matching rs2 that is not actually read must not stall
    drive(32'h58, 32'h0, 5'd1, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h5C, 32'h0, 5'd1, 1'b1, 5'd8, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    chk("unused_stall", bus_if.Stall, 32'h0);
    tick();
    chk("unused_pc", bus_if.PC_ex, 32'h5C);

    // Hazard on both sources: still exactly one stall cycle
    drive(32'h60, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h64, 32'h0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    chk("both_stall", bus_if.Stall, 32'h1);
    tick();
    chk("both_bub_valid", bus_if.Valid_ex, 32'h0);
    chk("both_stall_drop", bus_if.Stall, 32'h0);
    tick();
    chk("both_held_pc", bus_if.PC_ex, 32'h64);

    // Flush wins over a simultaneous hazard, then a second flush cycle
    drive(32'h68, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h6C, 32'h0, 5'd10, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
    bus_if.BranchTaken_ex = 1'b1;
    #1;
    chk("flush_stall", bus_if.Stall, 32'h0);
    tick();
    chk("flush_valid", bus_if.Valid_ex, 32'h0);
    chk("flush_memw",  bus_if.MemWrite_ex, 32'h0);
    chk("flush_rd",    bus_if.rdAddr_ex, 32'h0);
    tick();
    chk("flush2_valid", bus_if.Valid_ex, 32'h0);
    chk("flush2_pc",    bus_if.PC_ex, 32'h0);
    bus_if.BranchTaken_ex = 1'b0;
    tick();
    chk("post_flush_pc",   bus_if.PC_ex, 32'h6C);
    chk("post_flush_memw", bus_if.MemWrite_ex, 32'h1);

    // Third load-use stall (counter events: 3 stalls, 2 flushes)
    drive(32'h70, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h74, 32'h0, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu3_stall", bus_if.Stall, 32'h1);
    tick();
    chk("lu3_bub_valid", bus_if.Valid_ex, 32'h0);
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt", bus_if.StallCnt, 32'd3);
    chk("flush_cnt", bus_if.FlushCnt, 32'd2);
`endif
    tick();
    chk("lu3_held_pc", bus_if.PC_ex, 32'h74);

    // Reset asserted mid-stall clears outputs without waiting for an edge
    drive(32'h78, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h7C, 32'h0, 5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mid_stall_before", bus_if.Stall, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", bus_if.Stall, 32'h0);
    chk("mid_rst_memr",  bus_if.MemRead_ex, 32'h0);
    chk("mid_rst_valid", bus_if.Valid_ex, 32'h0);
    chk("mid_rst_pc",    bus_if.PC_ex, 32'h0);
`ifdef ID_EX_PERF_CNT_EN
    chk("mid_rst_scnt",  bus_if.StallCnt, 32'd0);
`endif
    tick();
    reset = 1'b0;
    tick();
    chk("after_rst_pc",    bus_if.PC_ex, 32'h7C);
    chk("after_rst_valid", bus_if.Valid_ex, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage RV32I core; sits directly upstream of the execute stage and produces its *_ex operands and controls.
- Registers all decode-stage controls and operands.
- Detects load-use hazards against the instruction currently in EX and emits Stall to freeze PC and IF/ID.
- Inserts bubbles on stall and on control-transfer flush (BranchTaken_ex).

Parameters:
- XLEN, 32, datapath width for Imm, rs1Data, rs2Data and PC.
- RA_W, 5, register address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ALUCode_id  input  4  ALU operation from decode
- ALUSrcA_id  input  1  ALU A select
- ALUSrcB_id  input  2  ALU B select
- Imm_id  input  XLEN  immediate
- rs1Addr_id, rs2Addr_id  input  RA_W  source register addresses
- rs1Used_id, rs2Used_id  input  1  instruction actually reads rs1/rs2
- rs1Data_id, rs2Data_id  input  XLEN  register-file read data
- PC_id  input  XLEN  instruction PC
- rdAddr_id  input  RA_W  destination register
- RegWrite_id, MemWrite_id, MemRead_id, MemtoReg_id  input  1  write-back/memory controls
- BranchTaken_ex  input  1  control transfer resolved taken in EX; flush request
- ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, Imm_ex, rs1Addr_ex, rs2Addr_ex, rs1Data_ex, rs2Data_ex, PC_ex, rdAddr_ex  output  (widths as *_id)  registered copies
- RegWrite_ex, MemWrite_ex, MemRead_ex, MemtoReg_ex  output  1  registered controls
- Valid_ex  output  1  EX holds a real instruction (0 = bubble)
- Stall  output  1  hold PC and IF/ID this cycle (combinational)

Behaviour:
- Reset: asynchronous, active-high. While reset is high, every registered output is 0 (a bubble).
- Hazard, combinational:
  - Hazard = MemRead_ex & Valid_ex & (rdAddr_ex != 0) & ((rs1Used_id & rs1Addr_id == rdAddr_ex) | (rs2Used_id & rs2Addr_id == rdAddr_ex)).
- Stall = Hazard & ~BranchTaken_ex. A taken branch kills the ID instruction, so no stall is needed in that case.
- Each rising clk edge, priority order:
  1. BranchTaken_ex = 1: load bubble.
  2. Hazard = 1: load bubble.
  3. Otherwise: capture all *_id into *_ex and set Valid_ex = 1.
- Bubble definition: all outputs 0, including ALUCode, Imm, data, PC, rdAddr and every control bit; Valid_ex = 0.
- Latency: exactly 1 cycle ID→EX. Stall lasts exactly one cycle per load-use, because the bubble clears MemRead_ex on the next edge.
- rd = x0 never triggers a hazard. A hazard on both rs1 and rs2 still produces a single-cycle stall.
- Back-to-back flush: each asserted cycle produces a bubble; Valid_ex stays 0.
- Reset asserted mid-stall: outputs clear immediately and Stall drops to 0 the same cycle (MemRead_ex = 0).
- No forwarding here; the EX stage resolves ALU-result hazards.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCnt [31:0] and FlushCnt [31:0], both reset to 0.
  - StallCnt increments on every edge where Stall = 1.
  - FlushCnt increments on every edge where BranchTaken_ex = 1.
  - Both wrap at 2^32 − 1 → 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package core_pkg:
  - XLEN and RA_W constants.
  - ALUCode encoding localparams, with ALU_ADD = 4'd0 as the bubble encoding.
  - ALUSrcB select encodings.
- One sub-module: hazard_detect, purely combinational, producing Hazard from the *_id address/used fields and rdAddr_ex/MemRead_ex/Valid_ex.
- Pipeline register remains in id_ex_stage.

Test Plan:
- Reset:
  - Stimulus: assert reset with all inputs nonzero, including PC_id = 0x100 and RegWrite_id = 1.
  - Response: all outputs 0 asynchronously; Stall = 0.
- Plain pass-through:
  - Stimulus: PC_id = 0x40, Imm_id = 0xFFFFFFF0, rdAddr_id = 5, RegWrite_id = 1.
  - Response: next edge gives PC_ex = 0x40, Imm_ex = 0xFFFFFFF0, rdAddr_ex = 5, Valid_ex = 1.
- Load-use stall:
  - Stimulus: lw x5 in EX (MemRead_ex = 1, rdAddr_ex = 5), then ID presents rs2Addr_id = 5 with rs2Used_id = 1.
  - Response: Stall = 1 for one cycle; next edge is a bubble (Valid_ex = 0, RegWrite_ex = 0); the following edge captures the held instruction; Stall = 0.
- No false hazard:
  - Stimulus: the same load-use but rdAddr_ex = 0, or rs2Used_id = 0.
  - Response: Stall = 0; instruction captured normally.
- Flush priority:
  - Stimulus: Hazard and BranchTaken_ex = 1 in the same cycle.
  - Response: Stall = 0; next edge is a bubble (MemWrite_ex = 0, rdAddr_ex = 0).
- Perf counters (ID_EX_PERF_CNT_EN):
  - Stimulus: 3 load-use stalls and 2 flushes.
  - Response: StallCnt = 3, FlushCnt = 2. A counter preloaded to 0xFFFFFFFF wraps to 0 after one further event.
